// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg: loader state encodings and state-class helpers. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package imem_loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_LEN   = 3'd1,
    LD_DATA  = 3'd2,
    LD_CHECK = 3'd3,
    LD_DONE  = 3'd4,
    LD_ERR   = 3'd5
  } ld_state_t;

  // States that accept host words.
  function automatic logic ld_busy(input ld_state_t s);
    return (s == LD_LEN) || (s == LD_DATA) || (s == LD_CHECK);
  endfunction

  // States in which start may launch a new load.
  function automatic logic ld_can_start(input ld_state_t s);
    return (s == LD_IDLE) || (s == LD_DONE) || (s == LD_ERR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader: streams a LEN/DATA/CHK framed image into instruction memory. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MAX_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  ld_state_t     state;
  ld_state_t     nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] len;
  logic [31:0]   xor_acc;
  logic          reset_seen;
  logic          xfer;

  assign xfer = s_valid & s_ready;

  // abort has priority over any transfer offered in the same cycle.
  always_comb begin
    nxt = state;
    case (state)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) nxt = LD_LEN;
      end
      LD_LEN: begin
        if (abort)                           nxt = LD_ERR;
        else if (xfer) begin
          if (s_data > 32'(MAX_WORDS))       nxt = LD_ERR;
          else if (s_data == 32'd0)          nxt = LD_CHECK;
          else                               nxt = LD_DATA;
        end
      end
      LD_DATA: begin
        if (abort)                                   nxt = LD_ERR;
        else if (xfer && (count == len - CW'(1)))    nxt = LD_CHECK;
      end
      LD_CHECK: begin
        if (abort)      nxt = LD_ERR;
        else if (xfer)  nxt = (s_data == xor_acc) ? LD_DONE : LD_ERR;
      end
      default: nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LD_IDLE;
      count      <= '0;
      len        <= '0;
      xor_acc    <= '0;
      reset_seen <= 1'b0;
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      core_rst   <= ~HOLD_AT_RESET;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state   <= nxt;
      s_ready <= ld_busy(nxt);
      busy    <= ld_busy(nxt);
      done    <= (nxt == LD_DONE);
      err     <= (nxt == LD_ERR);
      imem_we <= 1'b0;

      if (ld_can_start(state) && start) begin
        count   <= '0;
        xor_acc <= '0;
      end

      if (state == LD_LEN && nxt == LD_DATA)
        len <= s_data[CW-1:0];

      if (state == LD_DATA && xfer && !abort) begin
        imem_we    <= 1'b1;
        imem_addr  <= BASE_ADDR + (32'(count) << 2);
        imem_wdata <= s_data;
        xor_acc    <= xor_acc ^ s_data;
        count      <= count + CW'(1);
      end

      // Release happens on the CHECK acceptance edge, one cycle after the last write pulse.
      case (nxt)
        LD_DONE: begin
          core_rst   <= 1'b1;
          reset_seen <= 1'b1;
        end
        LD_IDLE: core_rst <= ~(HOLD_AT_RESET & ~reset_seen);
        default: core_rst <= 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader: vector table of frames plus hand-written corner sequences. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, s_valid;
  logic [31:0] s_data;
  logic        s_ready, imem_we, core_rst, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  typedef struct {
    logic [31:0] len;
    int          nsend;
    logic [31:0] w[4];
    logic        send_chk;
    logic [31:0] chk;
    logic        exp_done;
    logic        exp_err;
    int          exp_wr;
  } vec_t;

  vec_t vecs[7];

  imem_loader #(
    .MAX_WORDS    (1024),
    .BASE_ADDR    (32'h0),
    .HOLD_AT_RESET(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst  (core_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Each write pulse is one cycle wide, so one negedge sample per write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] len, input int nsend,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input logic send_chk, input logic [31:0] chk,
                         input logic exp_done, input logic exp_err, input int exp_wr);
    vecs[i].len      = len;
    vecs[i].nsend    = nsend;
    vecs[i].w[0]     = w0;
    vecs[i].w[1]     = w1;
    vecs[i].w[2]     = w2;
    vecs[i].w[3]     = w3;
    vecs[i].send_chk = send_chk;
    vecs[i].chk      = chk;
    vecs[i].exp_done = exp_done;
    vecs[i].exp_err  = exp_err;
    vecs[i].exp_wr   = exp_wr;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [31:0] d, input bit rnd);
    int n;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        @(negedge clk);
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_ready expected=ready data=%h", d);
    end else begin
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int exp_n, input logic [31:0] w[4]);
    check({tag, "_wr_count"}, 32'(wa.size()), 32'(exp_n));
    for (int k = 0; k < exp_n && k < wa.size(); k++) begin
      check({tag, "_wr_addr"}, wa[k], 32'(k * 4));
      check({tag, "_wr_data"}, wd[k], w[k]);
    end
  endtask

  task automatic run_vec(input int i);
    string tag;
    tag = $sformatf("vec%0d", i);
    wa.delete();
    wd.delete();
    pulse_start();
    send(vecs[i].len, 1'b0);
    for (int k = 0; k < vecs[i].nsend; k++) send(vecs[i].w[k], 1'b0);
    if (vecs[i].send_chk) send(vecs[i].chk, 1'b0);
    check({tag, "_done"},     32'(done),     32'(vecs[i].exp_done));
    check({tag, "_err"},      32'(err),      32'(vecs[i].exp_err));
    check({tag, "_core_rst"}, 32'(core_rst), 32'(vecs[i].exp_done));
    check({tag, "_busy"},     32'(busy),     32'd0);
    @(negedge clk);
    check_writes(tag, vecs[i].exp_wr, vecs[i].w);
  endtask

  logic [31:0] rw[16];
  logic [31:0] x;
  logic [31:0] hw[4];

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;

    // XOR(0x00500093, 0x00A00113, 0x002081B3) = 0x00D08033
    set_vec(0, 32'd3,    3, 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0, 1'b1, 32'h00D08033, 1'b1, 1'b0, 3);
    set_vec(1, 32'd3,    3, 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0, 1'b1, 32'h00000000, 1'b0, 1'b1, 3);
    set_vec(2, 32'd3,    3, 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0, 1'b1, 32'h00D08033, 1'b1, 1'b0, 3);
    set_vec(3, 32'd1025, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
    set_vec(4, 32'd0,    0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 0);
    set_vec(5, 32'd2,    2, 32'h12345678, 32'hFFFF0000, 32'h0, 32'h0, 1'b1, 32'hEDCB5678, 1'b1, 1'b0, 2);
    set_vec(6, 32'd1,    1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEE, 1'b0, 1'b1, 1);

    repeat (3) @(negedge clk);
    check("rst_core_rst",  32'(core_rst), 32'd0);
    check("rst_s_ready",   32'(s_ready),  32'd0);
    check("rst_imem_addr", imem_addr,     32'h0);
    check("rst_imem_wdata", imem_wdata,   32'h0);
    check("rst_flags",     {29'd0, busy, done, err}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_core_rst", 32'(core_rst), 32'd0);
    check("idle_s_ready",  32'(s_ready),  32'd0);
    check("idle_no_write", 32'(wa.size()), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i);

    // 16-word frame with random valid gaps and garbage data between words
    wa.delete(); wd.delete();
    x = '0;
    for (int k = 0; k < 16; k++) begin
      rw[k] = $urandom;
      x ^= rw[k];
    end
    pulse_start();
    send(32'd16, 1'b1);
    for (int k = 0; k < 16; k++) send(rw[k], 1'b1);
    send(x, 1'b1);
    check("rnd_done", 32'(done), 32'd1);
    @(negedge clk);
    check("rnd_wr_count", 32'(wa.size()), 32'd16);
    for (int k = 0; k < 16 && k < wa.size(); k++) begin
      check("rnd_wr_addr", wa[k], 32'(k * 4));
      check("rnd_wr_data", wd[k], rw[k]);
    end

    // Largest legal image
    wa.delete(); wd.delete();
    x = '0;
    pulse_start();
    send(32'd1024, 1'b0);
    for (int k = 0; k < 1024; k++) begin
      send(32'(k * 3 + 1), 1'b0);
      x ^= 32'(k * 3 + 1);
    end
    send(x, 1'b0);
    check("max_done", 32'(done), 32'd1);
    @(negedge clk);
    check("max_wr_count", 32'(wa.size()), 32'd1024);
    if (wa.size() == 1024) begin
      check("max_last_addr", wa[1023], 32'hFFC);
      check("max_last_data", wd[1023], 32'(1023 * 3 + 1));
    end

    // start during a load is ignored; abort in DONE is ignored
    wa.delete(); wd.delete();
    hw[0] = 32'hA5A5_0001; hw[1] = 32'h0F0F_0002; hw[2] = '0; hw[3] = '0;
    pulse_start();
    check("load_core_rst", 32'(core_rst), 32'd0);
    send(32'd2, 1'b0);
    pulse_start();
    send(hw[0], 1'b0);
    send(hw[1], 1'b0);
    send(hw[0] ^ hw[1], 1'b0);
    check("busy_start_done", 32'(done), 32'd1);
    @(negedge clk);
    check_writes("busy_start", 2, hw);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("done_abort_done", 32'(done), 32'd1);
    check("done_abort_err",  32'(err),  32'd0);

    // abort with a word offered after 2 of 4 data words
    wa.delete(); wd.delete();
    pulse_start();
    send(32'd4, 1'b0);
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b0);
    s_valid = 1'b1; s_data = 32'h3333_3333; abort = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; abort = 1'b0;
    check("abort_err",      32'(err),      32'd1);
    check("abort_s_ready",  32'(s_ready),  32'd0);
    check("abort_core_rst", 32'(core_rst), 32'd0);
    repeat (2) @(negedge clk);
    check("abort_wr_count", 32'(wa.size()), 32'd2);

    // async reset mid-DATA, while a write pulse is in flight
    pulse_start();
    send(32'd4, 1'b0);
    send(32'h4444_4444, 1'b0);
    send(32'h5555_5555, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("arst_imem_we",   32'(imem_we),  32'd0);
    check("arst_s_ready",   32'(s_ready),  32'd0);
    check("arst_imem_addr", imem_addr,     32'h0);
    check("arst_wdata",     imem_wdata,    32'h0);
    check("arst_flags",     {29'd0, busy, done, err}, 32'd0);
    check("arst_core_rst",  32'(core_rst), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_arst_core_rst", 32'(core_rst), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
